// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, digit table and scanner state type.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int NUM_POS    = 8;
  localparam int NUM_DIGITS = 6;
  localparam int SIGN_POS   = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Entry i is the pattern for decimal digit i.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_vec_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] code;
    code = SEG_E;
    if (bcd < 4'd10) code = SEG_DIGITS[bcd];
    return code;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder with blank and minus overrides.
// Codes 10..15 render as 'E'; blank takes priority over minus.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);

  always_comb begin
    seg = bcd_to_seg(bcd);
    if (minus) seg = SEG_MINUS;
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes six double-buffered BCD digits plus a sign onto an
// 8-position common-anode display, with blank gaps and leading-zero blanking.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 100,
  parameter int LZ_SUPPRESS  = 1,
  parameter int DP_POS       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] digit_4,
  input  logic [3:0] digit_5,
  input  logic       sign,
  input  logic       digits_valid,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);
  localparam bit            DP_EN  = (DP_POS >= 0) && (DP_POS < NUM_POS);
  localparam logic [2:0]    DP_IDX = DP_EN ? 3'(DP_POS) : 3'd0;

  state_e          state_q, state_d;
  logic [RW-1:0]   drv_cnt_q, drv_cnt_d;
  logic [BW-1:0]   blk_cnt_q, blk_cnt_d;
  logic [2:0]      pos_q, pos_d;
  bcd_vec_t        pend_dig_q, pend_dig_d;
  logic            pend_sign_q, pend_sign_d;
  bcd_vec_t        shadow_dig_q, shadow_dig_d;
  logic            shadow_sign_q, shadow_sign_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic [NUM_POS-1:0]      show;
  logic                    seen_nonzero;
  logic [NUM_POS-1:0][3:0] pos_bcd;
  logic                    lit;
  logic                    dec_minus;
  logic [6:0]              dec_seg;

  // Sequencing, counters and buffering
  always_comb begin
    state_d       = state_q;
    drv_cnt_d     = drv_cnt_q;
    blk_cnt_d     = blk_cnt_q;
    pos_d         = pos_q;
    shadow_dig_d  = shadow_dig_q;
    shadow_sign_d = shadow_sign_q;
    pend_dig_d    = pend_dig_q;
    pend_sign_d   = pend_sign_q;

    if (digits_valid) begin
      pend_dig_d  = {digit_5, digit_4, digit_3, digit_2, digit_1, digit_0};
      pend_sign_d = sign;
    end

    unique case (state_q)
      ST_BLANK: begin
        if (blk_cnt_q == B_LAST) begin
          state_d   = ST_DRIVE;
          blk_cnt_d = '0;
          drv_cnt_d = '0;
          // Frame boundary: shadow takes pending as it stood before this edge.
          if (pos_q == 3'd0) begin
            shadow_dig_d  = pend_dig_q;
            shadow_sign_d = pend_sign_q;
          end
        end else begin
          blk_cnt_d = blk_cnt_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (drv_cnt_q == R_LAST) begin
          state_d   = ST_BLANK;
          drv_cnt_d = '0;
          pos_d     = pos_q + 3'd1;
        end else begin
          drv_cnt_d = drv_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Per-position visibility; a digit is kept once any more-significant digit is nonzero.
  always_comb begin
    show         = '0;
    seen_nonzero = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      seen_nonzero = seen_nonzero | (shadow_dig_d[NUM_DIGITS-1-k] != 4'd0);
      show[NUM_DIGITS-1-k] = seen_nonzero || (LZ_SUPPRESS == 0);
    end
    show[0]        = 1'b1;
    show[SIGN_POS] = shadow_sign_d;
    show[7]        = 1'b0;
  end

  // Outputs decode next-state values so the registers line up with the state.
  always_comb begin
    pos_bcd   = {8'h00, shadow_dig_d};
    lit       = (state_d == ST_DRIVE) && show[pos_d];
    dec_minus = (pos_d == 3'(SIGN_POS));
    an_d      = lit ? ~(8'd1 << pos_d) : 8'hFF;
    seg_d     = dec_seg;
    dp_d      = ~(lit && DP_EN && (pos_d == DP_IDX));
  end

  seg7_decode u_decode (
    .bcd   (pos_bcd[pos_d]),
    .blank (~lit),
    .minus (dec_minus),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      drv_cnt_q     <= '0;
      blk_cnt_q     <= '0;
      pos_q         <= '0;
      pend_dig_q    <= '0;
      pend_sign_q   <= 1'b0;
      shadow_dig_q  <= '0;
      shadow_sign_q <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      drv_cnt_q     <= drv_cnt_d;
      blk_cnt_q     <= blk_cnt_d;
      pos_q         <= pos_d;
      pend_dig_q    <= pend_dig_d;
      pend_sign_q   <= pend_sign_d;
      shadow_dig_q  <= shadow_dig_d;
      shadow_sign_q <= shadow_sign_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a frame-arithmetic display model checked every
// cycle, plus literal expectations for the scripted scenarios.
module tb_seven_seg_scanner;

  localparam int R     = 4;
  localparam int B     = 2;
  localparam int SLOT  = R + B;
  localparam int FRAME = 8 * SLOT;
  localparam int DPP   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0, d5 = '0;
  logic       sign = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int failures = 0;

  int         m_t;
  logic [3:0] m_pend [6];
  logic [3:0] m_sh   [6];
  logic       m_pend_sign, m_sh_sign;
  bit         started = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B),
    .LZ_SUPPRESS  (1),
    .DP_POS       (DPP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_0      (d0),
    .digit_1      (d1),
    .digit_2      (d2),
    .digit_3      (d3),
    .digit_4      (d4),
    .digit_5      (d5),
    .sign         (sign),
    .digits_valid (dv),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  function automatic logic [6:0] digit_code(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // Display contents at cycle t after reset release, from the frame timing rules.
  function automatic logic [15:0] expect_out(input int t);
    int phase, pos, w;
    bit shown;
    logic [6:0] code;
    logic [7:0] a;
    phase = t % FRAME;
    pos   = phase / SLOT;
    w     = phase % SLOT;
    if (w < B) return {8'hFF, 7'h7F, 1'b1};
    shown = 0;
    code  = 7'h7F;
    if (pos == 0) shown = 1;
    else if (pos <= 5) begin
      for (int k = pos; k <= 5; k++) if (m_sh[k] != 4'd0) shown = 1;
    end else if (pos == 6) shown = m_sh_sign;
    if (shown) code = (pos == 6) ? 7'b0111111 : digit_code(m_sh[pos]);
    a = 8'hFF;
    if (shown) a[pos] = 1'b0;
    return {a, shown ? code : 7'h7F, (shown && pos == DPP) ? 1'b0 : 1'b1};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got an=%h seg=%b dp=%b expected an=%h seg=%b dp=%b",
               name, m_t, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
    end
  endtask

  function automatic logic [15:0] lit(input logic [7:0] a, input logic [6:0] s, input logic p);
    return {a, s, p};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0;
      for (int i = 0; i < 6; i++) begin
        m_pend[i] = '0;
        m_sh[i]   = '0;
      end
      m_pend_sign = 1'b0;
      m_sh_sign   = 1'b0;
    end else begin
      m_t++;
      if (m_t % FRAME == B) begin
        m_sh      = m_pend;
        m_sh_sign = m_pend_sign;
      end
      if (dv) begin
        m_pend[0] = d0; m_pend[1] = d1; m_pend[2] = d2;
        m_pend[3] = d3; m_pend[4] = d4; m_pend[5] = d5;
        m_pend_sign = sign;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (started && !reset) check("scan", {an, seg, dp}, expect_out(m_t));
  end

  task automatic goto_t(input int target);
    int g;
    g = 0;
    while (m_t != target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (m_t != target) begin
      checks++;
      failures++;
      $display("FAIL goto_t timeout t=%0d target=%0d", m_t, target);
    end
  endtask

  task automatic drive(input logic [23:0] digs, input logic s);
    d0 = digs[3:0];   d1 = digs[7:4];   d2 = digs[11:8];
    d3 = digs[15:12]; d4 = digs[19:16]; d5 = digs[23:20];
    sign = s;
  endtask

  task automatic load(input logic [23:0] digs, input logic s);
    drive(digs, s);
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  initial begin
    logic [23:0] r;
    int nsig, cur, delta;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hold", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));
    reset   = 1'b0;
    started = 1;

    goto_t(1);  check("rst_blank1", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));
    goto_t(2);  check("rst_pos0",   {an, seg, dp}, lit(8'hFE, 7'b1000000, 1'b1));
    goto_t(5);  check("rst_pos0_end", {an, seg, dp}, lit(8'hFE, 7'b1000000, 1'b1));
    goto_t(8);  check("rst_pos1_blank", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));

    goto_t(10); load(24'h000255, 1'b0);
    goto_t(14); check("tear_free", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));
    goto_t(50); check("v255_p0", {an, seg, dp}, lit(8'hFE, 7'b0010010, 1'b1));
    goto_t(56); check("v255_p1", {an, seg, dp}, lit(8'hFD, 7'b0010010, 1'b1));
    goto_t(62); check("v255_p2", {an, seg, dp}, lit(8'hFB, 7'b0100100, 1'b1));
    goto_t(68); check("v255_p3", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));

    goto_t(70);  load(24'h004578, 1'b1);
    goto_t(98);  check("neg_p0", {an, seg, dp}, lit(8'hFE, 7'b0000000, 1'b1));
    goto_t(116); check("neg_p3_dp", {an, seg, dp}, lit(8'hF7, 7'b0011001, 1'b0));
    goto_t(122); check("neg_p4", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));
    goto_t(134); check("neg_p6", {an, seg, dp}, lit(8'hBF, 7'b0111111, 1'b1));

    goto_t(145); load(24'h000C01, 1'b0);
    check("boundary_old", {an, seg, dp}, lit(8'hFE, 7'b0000000, 1'b1));
    goto_t(194); check("boundary_new", {an, seg, dp}, lit(8'hFE, 7'b1111001, 1'b1));
    goto_t(200); check("inner_zero", {an, seg, dp}, lit(8'hFD, 7'b1000000, 1'b1));
    goto_t(206); check("code_e", {an, seg, dp}, lit(8'hFB, 7'b0000110, 1'b1));
    goto_t(212); check("dp_blanked", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));

    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        nsig = $urandom_range(6);
        r = '0;
        for (int i = 0; i < 6; i++)
          if (i < nsig)
            r[i*4 +: 4] = ($urandom_range(9) == 0) ? 4'($urandom_range(15, 10))
                                                   : 4'($urandom_range(9));
        drive(r, 1'($urandom_range(1)));
        dv = 1'b1;
      end else begin
        dv = 1'b0;
      end
    end
    @(negedge clk);
    dv = 1'b0;

    cur   = m_t;
    delta = (21 - (cur % FRAME) + FRAME) % FRAME;
    if (delta == 0) delta = FRAME;
    goto_t(cur + delta);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    goto_t(1); check("rerun_blank", {an, seg, dp}, lit(8'hFF, 7'h7F, 1'b1));
    goto_t(2); check("rerun_pos0", {an, seg, dp}, lit(8'hFE, 7'b1000000, 1'b1));
    goto_t(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
